// File: rtl/hept_stage_sequencer.sv
// ---------------------------------------------------------------------------
// hept_stage_sequencer
//
// Runs the three HEPT attention stages (transpose_qk, pairwise_dist_sq_rbf,
// mask_and_normalize) once per head, for N_HEADS heads. Both sides use
// ap_ctrl_hs handshakes. The block also keeps busy-cycle profiling counters
// and a per-invocation watchdog, so a hung stage ends the run with err set
// instead of stalling the kernel.
//
// Ports:
//   ap_clk, ap_rst      clock; synchronous active-high reset
//   ap_start            run request (sampled only in IDLE)
//   ap_done, ap_ready   one-cycle pulse at the end of a run
//   ap_idle             high only while IDLE
//   s_start[2:0]        per-stage ap_start (bit k = stage k)
//   s_ready[2:0]        per-stage ap_ready
//   s_done[2:0]         per-stage ap_done
//   head_idx            head currently (or last) processed
//   err                 watchdog fired during the last run
//   cyc_total           busy cycles of the current/last run (saturating)
//   stage_cyc           per-stage busy cycles, slice k = stage k (saturating)
//   dbg_state           FSM state, for debug and checkers
//
// Handshake: s_start[k] is a level request held until the stage reports
// s_ready[k] or s_done[k] in the same cycle; only bit k of s_ready/s_done is
// observed, and only while a stage is in flight (ISSUE or WAIT). s_done[k]
// completes the stage whether or not s_ready[k] was seen first.
// ---------------------------------------------------------------------------
module hept_stage_sequencer #(
    parameter int N_HEADS = 2,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 65535,
    localparam int HEAD_W = (N_HEADS > 1) ? $clog2(N_HEADS) : 1
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_ready,
    output logic                 ap_idle,
    output logic [2:0]           s_start,
    input  logic [2:0]           s_ready,
    input  logic [2:0]           s_done,
    output logic [HEAD_W-1:0]    head_idx,
    output logic                 err,
    output logic [CNT_W-1:0]     cyc_total,
    output logic [3*CNT_W-1:0]   stage_cyc,
    output logic [1:0]           dbg_state
);

    // The watchdog counts 0..TIMEOUT-1 within one invocation; the cycle on
    // which it reads TIMEOUT-1 is the TIMEOUT-th busy cycle of that stage.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [HEAD_W-1:0] LAST_HEAD = HEAD_W'(N_HEADS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_k;
    logic [HEAD_W-1:0]  r_head;
    logic               r_err;
    logic               r_done;
    logic               r_idle;
    logic [2:0]         r_start;
    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_stage [3];
    logic [WD_W-1:0]    r_wd;

    logic               w_done_k;
    logic               w_ready_k;
    logic               w_timeout;

    assign w_done_k  = s_done[r_k];
    assign w_ready_k = s_ready[r_k];
    assign w_timeout = (TIMEOUT != 0) && (r_wd == WD_LAST);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
            r_k     <= 2'd0;
            r_head  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
            r_start <= 3'b000;
            r_total <= '0;
            for (int i = 0; i < 3; i++) begin
                r_stage[i] <= '0;
            end
            r_wd    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_state <= ST_ISSUE;
                        r_k     <= 2'd0;
                        r_head  <= '0;
                        r_err   <= 1'b0;
                        r_idle  <= 1'b0;
                        r_start <= 3'b001;
                        r_total <= '0;
                        for (int i = 0; i < 3; i++) begin
                            r_stage[i] <= '0;
                        end
                        r_wd    <= '0;
                    end
                end

                ST_ISSUE, ST_WAIT: begin
                    // Every in-flight cycle is charged to the run and to stage k,
                    // including the cycle on which done or the timeout is seen.
                    if (r_total != '1) begin
                        r_total <= r_total + 1'b1;
                    end
                    if (r_stage[r_k] != '1) begin
                        r_stage[r_k] <= r_stage[r_k] + 1'b1;
                    end

                    if (w_done_k) begin
                        // Completion wins over a timeout on the same cycle.
                        r_wd <= '0;
                        if (r_k != 2'd2) begin
                            r_k     <= r_k + 2'd1;
                            r_state <= ST_ISSUE;
                            r_start <= (r_k == 2'd0) ? 3'b010 : 3'b100;
                        end else if (r_head != LAST_HEAD) begin
                            r_head  <= r_head + 1'b1;
                            r_k     <= 2'd0;
                            r_state <= ST_ISSUE;
                            r_start <= 3'b001;
                        end else begin
                            r_state <= ST_DONE;
                            r_start <= 3'b000;
                            r_done  <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        // Abandon the run; the hung stage is left as it is.
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_start <= 3'b000;
                        r_done  <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                        if ((r_state == ST_ISSUE) && w_ready_k) begin
                            r_state <= ST_WAIT;
                            r_start <= 3'b000;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                    r_start <= 3'b000;
                end
            endcase
        end
    end

    assign ap_done   = r_done;
    assign ap_ready  = r_done;
    assign ap_idle   = r_idle;
    assign s_start   = r_start;
    assign head_idx  = r_head;
    assign err       = r_err;
    assign cyc_total = r_total;
    assign stage_cyc = {r_stage[2], r_stage[1], r_stage[0]};
    assign dbg_state = r_state;

endmodule
